// File: rtl/ensemble_pkg.sv
// Shared constants and helpers for the classifier-ensemble AXI-Stream front end.
package ensemble_pkg;

   localparam int unsigned MAX_CH         = 8;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_CNT_WIDTH  = 16;

   typedef enum logic {
      MODE_INDEP    = 1'b0,
      MODE_LOCKSTEP = 1'b1
   } mode_e;

   // Low bit index of element idx in a flattened bus of width-bit elements.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/ensemble_axis_wrapper_skid.sv
// Two-entry AXI-Stream skid buffer: registered ready, head beat held in a register,
// pop decided externally so the wrapper can gang channels together.
module axis_skid_buffer
   import ensemble_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32'd8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata_i,
   input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
   input  logic                  s_tvalid_i,
   input  logic                  s_tlast_i,
   output logic                  s_tready_o,
   output logic [DATA_WIDTH-1:0] m_tdata_o,
   output logic [KEEP_WIDTH-1:0] m_tkeep_o,
   output logic                  m_tlast_o,
   output logic                  nonempty_o,
   output logic                  nonempty_next_o,
   input  logic                  pop_i
);

   localparam int unsigned BW = DATA_WIDTH + KEEP_WIDTH + 1;

   logic [BW-1:0] head_q, head_d, tail_q, tail_d, in_beat_s;
   logic [1:0]    occ_q, occ_d;
   logic          rdy_q, rdy_d, push_s;

   assign in_beat_s = {s_tdata_i, s_tkeep_i, s_tlast_i};
   assign push_s    = s_tvalid_i & rdy_q;

   // Occupancy / storage next-state; tail only ever holds the second-oldest beat.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         2'd0: begin
            if (push_s) begin
               head_d = in_beat_s;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd0;
            end
         end
         2'd1: begin
            case ({push_s, pop_i})
               2'b11:   head_d = in_beat_s;
               2'b10: begin
                  tail_d = in_beat_s;
                  occ_d  = 2'd2;
               end
               2'b01:   occ_d  = 2'd0;
               default: occ_d  = 2'd1;
            endcase
         end
         2'd2: begin
            if (pop_i) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd2;
            end
         end
         default: occ_d = 2'd0;
      endcase
      rdy_d = (occ_d != 2'd2);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         rdy_q  <= 1'b0;
         head_q <= {BW{1'b0}};
         tail_q <= {BW{1'b0}};
      end else begin
         occ_q  <= occ_d;
         rdy_q  <= rdy_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign s_tready_o      = rdy_q;
   assign m_tdata_o       = head_q[BW-1 -: DATA_WIDTH];
   assign m_tkeep_o       = head_q[KEEP_WIDTH:1];
   assign m_tlast_o       = head_q[0];
   assign nonempty_o      = (occ_q != 2'd0);
   assign nonempty_next_o = (occ_d != 2'd0);

endmodule

// File: rtl/ensemble_axis_wrapper.sv
// N-channel AXI-Stream front end for the classifier ensemble, with an optional
// lockstep mode that keeps channels beat-aligned, plus per-channel counters.
module ensemble_axis_wrapper
   import ensemble_pkg::*;
#(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32'd8,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           lockstep_req,
   output logic                           lockstep_active,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_CH*KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic [NUM_CH-1:0]              s_axis_tvalid,
   output logic [NUM_CH-1:0]              s_axis_tready,
   input  logic [NUM_CH-1:0]              s_axis_tlast,
   output logic [NUM_CH*DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [NUM_CH*KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic [NUM_CH-1:0]              m_axis_tvalid,
   input  logic [NUM_CH-1:0]              m_axis_tready,
   output logic [NUM_CH-1:0]              m_axis_tlast,
   output logic [NUM_CH*CNT_WIDTH-1:0]    beat_count,
   output logic [NUM_CH*CNT_WIDTH-1:0]    pkt_count
);

   logic [NUM_CH-1:0]    nonempty_s, nonempty_next_s, pop_s, m_tlast_s, m_tvalid_s;
   logic                 all_avail_s, all_rdy_s, idle_s;
   mode_e                mode_q, mode_d;
   logic [CNT_WIDTH-1:0] beat_q [NUM_CH];
   logic [CNT_WIDTH-1:0] beat_d [NUM_CH];
   logic [CNT_WIDTH-1:0] pkt_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] pkt_d  [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axis_skid_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .KEEP_WIDTH (KEEP_WIDTH)
      ) u_skid (
         .clk             (clk),
         .rst_n           (rst_n),
         .s_tdata_i       (s_axis_tdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH]),
         .s_tkeep_i       (s_axis_tkeep[slice_lo(g, KEEP_WIDTH) +: KEEP_WIDTH]),
         .s_tvalid_i      (s_axis_tvalid[g]),
         .s_tlast_i       (s_axis_tlast[g]),
         .s_tready_o      (s_axis_tready[g]),
         .m_tdata_o       (m_axis_tdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH]),
         .m_tkeep_o       (m_axis_tkeep[slice_lo(g, KEEP_WIDTH) +: KEEP_WIDTH]),
         .m_tlast_o       (m_tlast_s[g]),
         .nonempty_o      (nonempty_s[g]),
         .nonempty_next_o (nonempty_next_s[g]),
         .pop_i           (pop_s[g])
      );
      assign beat_count[slice_lo(g, CNT_WIDTH) +: CNT_WIDTH] = beat_q[g];
      assign pkt_count[slice_lo(g, CNT_WIDTH) +: CNT_WIDTH]  = pkt_q[g];
   end

   assign all_avail_s = &nonempty_s;
   assign all_rdy_s   = &m_axis_tready;
   assign idle_s      = ~|nonempty_next_s;

   // Valid/pop steering: in lockstep every channel shows and pops together.
   always_comb begin
      if (mode_q == MODE_LOCKSTEP) begin
         m_tvalid_s = {NUM_CH{all_avail_s}};
         pop_s      = {NUM_CH{all_avail_s & all_rdy_s}};
      end else begin
         m_tvalid_s = nonempty_s;
         pop_s      = nonempty_s & m_axis_tready;
      end
   end

   // Mode only changes once nothing is buffered, so no beat straddles a switch.
   always_comb begin
      if (idle_s) begin
         mode_d = lockstep_req ? MODE_LOCKSTEP : MODE_INDEP;
      end else begin
         mode_d = mode_q;
      end
   end

   // Counter next-state; free-running, wraps naturally.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         beat_d[i] = beat_q[i] + {{(CNT_WIDTH-1){1'b0}}, pop_s[i]};
         pkt_d[i]  = pkt_q[i]  + {{(CNT_WIDTH-1){1'b0}}, pop_s[i] & m_tlast_s[i]};
      end
   end

   // Mode and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_INDEP;
         for (int i = 0; i < NUM_CH; i++) begin
            beat_q[i] <= {CNT_WIDTH{1'b0}};
            pkt_q[i]  <= {CNT_WIDTH{1'b0}};
         end
      end else begin
         mode_q <= mode_d;
         for (int i = 0; i < NUM_CH; i++) begin
            beat_q[i] <= beat_d[i];
            pkt_q[i]  <= pkt_d[i];
         end
      end
   end

   assign lockstep_active = (mode_q == MODE_LOCKSTEP);
   assign m_axis_tvalid   = m_tvalid_s;
   assign m_axis_tlast    = m_tlast_s;

endmodule

// File: tb/tb_ensemble_axis_wrapper.sv
// Directed, table-driven bench for ensemble_axis_wrapper (3 channels, 4-bit counters).
module tb_ensemble_axis_wrapper;

   localparam int NCH = 3;
   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int CW  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              lockstep_req = 1'b0;
   logic              lockstep_active;
   logic [NCH*DW-1:0] s_axis_tdata = '0;
   logic [NCH*KW-1:0] s_axis_tkeep = '0;
   logic [NCH-1:0]    s_axis_tvalid = '0;
   logic [NCH-1:0]    s_axis_tready;
   logic [NCH-1:0]    s_axis_tlast = '0;
   logic [NCH*DW-1:0] m_axis_tdata;
   logic [NCH*KW-1:0] m_axis_tkeep;
   logic [NCH-1:0]    m_axis_tvalid;
   logic [NCH-1:0]    m_axis_tready = '0;
   logic [NCH-1:0]    m_axis_tlast;
   logic [NCH*CW-1:0] beat_count;
   logic [NCH*CW-1:0] pkt_count;

   int n_checks = 0;
   int n_fail   = 0;

   ensemble_axis_wrapper #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .lockstep_req(lockstep_req), .lockstep_active(lockstep_active),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .beat_count(beat_count), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            lk;
      logic [2:0]      sv;
      logic [2:0]      sl;
      logic [2:0][31:0] sd;
      logic [2:0]      mr;
      logic [2:0]      e_mv;
      logic [2:0]      e_sr;
      logic [2:0][31:0] e_d;
      logic            e_la;
      logic [2:0][3:0] e_bc;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(input logic lk, input logic [2:0] sv, input logic [2:0] sl,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [2:0] mr, input logic [2:0] e_mv, input logic [2:0] e_sr,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                               input logic e_la, input logic [3:0] b0, input logic [3:0] b1,
                               input logic [3:0] b2);
      vec_t v;
      v.lk = lk; v.sv = sv; v.sl = sl; v.mr = mr;
      v.sd[0] = d0; v.sd[1] = d1; v.sd[2] = d2;
      v.e_mv = e_mv; v.e_sr = e_sr; v.e_la = e_la;
      v.e_d[0] = e0; v.e_d[1] = e1; v.e_d[2] = e2;
      v.e_bc[0] = b0; v.e_bc[1] = b1; v.e_bc[2] = b2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // lk sv sl  d0 d1 d2  mr | mv sr  e0 e1 e2  la  bc0 bc1 bc2
      vecs[0]  = mk(1'b0, 3'b001, 3'b000, 32'h11, 32'h0,  32'h0,  3'b111, 3'b001, 3'b111, 32'h11, 32'h0,  32'h0,  1'b0, 4'd0, 4'd0, 4'd0);
      vecs[1]  = mk(1'b0, 3'b001, 3'b000, 32'h12, 32'h0,  32'h0,  3'b111, 3'b001, 3'b111, 32'h12, 32'h0,  32'h0,  1'b0, 4'd1, 4'd0, 4'd0);
      vecs[2]  = mk(1'b0, 3'b001, 3'b000, 32'h13, 32'h0,  32'h0,  3'b111, 3'b001, 3'b111, 32'h13, 32'h0,  32'h0,  1'b0, 4'd2, 4'd0, 4'd0);
      vecs[3]  = mk(1'b0, 3'b001, 3'b001, 32'h14, 32'h0,  32'h0,  3'b111, 3'b001, 3'b111, 32'h14, 32'h0,  32'h0,  1'b0, 4'd3, 4'd0, 4'd0);
      vecs[4]  = mk(1'b0, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b0, 4'd4, 4'd0, 4'd0);
      vecs[5]  = mk(1'b0, 3'b010, 3'b000, 32'h0,  32'hA,  32'h0,  3'b101, 3'b010, 3'b111, 32'h0,  32'hA,  32'h0,  1'b0, 4'd4, 4'd0, 4'd0);
      vecs[6]  = mk(1'b0, 3'b010, 3'b000, 32'h0,  32'hB,  32'h0,  3'b101, 3'b010, 3'b101, 32'h0,  32'hA,  32'h0,  1'b0, 4'd4, 4'd0, 4'd0);
      vecs[7]  = mk(1'b0, 3'b010, 3'b010, 32'h0,  32'hC,  32'h0,  3'b101, 3'b010, 3'b101, 32'h0,  32'hA,  32'h0,  1'b0, 4'd4, 4'd0, 4'd0);
      vecs[8]  = mk(1'b0, 3'b010, 3'b010, 32'h0,  32'hC,  32'h0,  3'b111, 3'b010, 3'b111, 32'h0,  32'hB,  32'h0,  1'b0, 4'd4, 4'd1, 4'd0);
      vecs[9]  = mk(1'b0, 3'b010, 3'b010, 32'h0,  32'hC,  32'h0,  3'b111, 3'b010, 3'b111, 32'h0,  32'hC,  32'h0,  1'b0, 4'd4, 4'd2, 4'd0);
      vecs[10] = mk(1'b0, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b0, 4'd4, 4'd3, 4'd0);
      vecs[11] = mk(1'b0, 3'b001, 3'b001, 32'h55, 32'h0,  32'h0,  3'b110, 3'b001, 3'b111, 32'h55, 32'h0,  32'h0,  1'b0, 4'd4, 4'd3, 4'd0);
      vecs[12] = mk(1'b1, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b110, 3'b001, 3'b111, 32'h55, 32'h0,  32'h0,  1'b0, 4'd4, 4'd3, 4'd0);
      vecs[13] = mk(1'b1, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b110, 3'b001, 3'b111, 32'h55, 32'h0,  32'h0,  1'b0, 4'd4, 4'd3, 4'd0);
      vecs[14] = mk(1'b1, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b1, 4'd5, 4'd3, 4'd0);
      vecs[15] = mk(1'b1, 3'b011, 3'b000, 32'h21, 32'h31, 32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b1, 4'd5, 4'd3, 4'd0);
      vecs[16] = mk(1'b1, 3'b100, 3'b000, 32'h0,  32'h0,  32'h41, 3'b011, 3'b111, 3'b111, 32'h21, 32'h31, 32'h41, 1'b1, 4'd5, 4'd3, 4'd0);
      vecs[17] = mk(1'b1, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b011, 3'b111, 3'b111, 32'h21, 32'h31, 32'h41, 1'b1, 4'd5, 4'd3, 4'd0);
      vecs[18] = mk(1'b1, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b1, 4'd6, 4'd4, 4'd1);
      vecs[19] = mk(1'b0, 3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  3'b111, 3'b000, 3'b111, 32'h0,  32'h0,  32'h0,  1'b0, 4'd6, 4'd4, 4'd1);

      // Reset state
      step();
      step();
      chk("rst_s_tready", {29'd0, s_axis_tready}, 32'd0);
      chk("rst_m_tvalid", {29'd0, m_axis_tvalid}, 32'd0);
      chk("rst_lockstep", {31'd0, lockstep_active}, 32'd0);
      chk("rst_beat", {20'd0, beat_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rel_s_tready", {29'd0, s_axis_tready}, 32'h7);

      s_axis_tkeep = {NCH{4'hF}};
      for (int i = 0; i < 20; i++) begin
         lockstep_req  = vecs[i].lk;
         s_axis_tvalid = vecs[i].sv;
         s_axis_tlast  = vecs[i].sl;
         m_axis_tready = vecs[i].mr;
         for (int c = 0; c < NCH; c++) s_axis_tdata[c*DW +: DW] = vecs[i].sd[c];
         step();
         chk($sformatf("v%0d_m_tvalid", i), {29'd0, m_axis_tvalid}, {29'd0, vecs[i].e_mv});
         chk($sformatf("v%0d_s_tready", i), {29'd0, s_axis_tready}, {29'd0, vecs[i].e_sr});
         chk($sformatf("v%0d_lockstep", i), {31'd0, lockstep_active}, {31'd0, vecs[i].e_la});
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("v%0d_beat%0d", i, c), {28'd0, beat_count[c*CW +: CW]}, {28'd0, vecs[i].e_bc[c]});
            if (vecs[i].e_mv[c])
               chk($sformatf("v%0d_tdata%0d", i, c), m_axis_tdata[c*DW +: DW], vecs[i].e_d[c]);
         end
      end
      chk("pkt0", {28'd0, pkt_count[0 +: CW]}, 32'd2);
      chk("pkt1", {28'd0, pkt_count[CW +: CW]}, 32'd1);
      chk("pkt2", {28'd0, pkt_count[2*CW +: CW]}, 32'd0);

      // Mid-packet reset with ch0 full
      s_axis_tlast  = '0;
      m_axis_tready = 3'b110;
      s_axis_tvalid = 3'b001;
      s_axis_tdata[0 +: DW] = 32'h77;
      step();
      s_axis_tdata[0 +: DW] = 32'h78;
      step();
      chk("full_s_tready0", {31'd0, s_axis_tready[0]}, 32'd0);
      s_axis_tvalid = '0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_m_tvalid", {29'd0, m_axis_tvalid}, 32'd0);
      chk("arst_tdata0", m_axis_tdata[0 +: DW], 32'd0);
      chk("arst_beat", {20'd0, beat_count}, 32'd0);
      chk("arst_pkt", {20'd0, pkt_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_axis_tready = 3'b111;
      step();
      chk("arel_s_tready", {29'd0, s_axis_tready}, 32'h7);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("arel_no_old_%0d", i), {29'd0, m_axis_tvalid}, 32'd0);
      end

      // Counter wrap: 17 single-beat packets on ch2
      for (int i = 0; i < 17; i++) begin
         s_axis_tvalid = 3'b100;
         s_axis_tlast  = 3'b100;
         s_axis_tdata[2*DW +: DW] = 32'h100 + i;
         s_axis_tkeep[2*KW +: KW] = i[3:0];
         step();
         chk($sformatf("wrap_tvalid_%0d", i), {31'd0, m_axis_tvalid[2]}, 32'd1);
         chk($sformatf("wrap_tdata_%0d", i), m_axis_tdata[2*DW +: DW], 32'h100 + i);
         chk($sformatf("wrap_tkeep_%0d", i), {28'd0, m_axis_tkeep[2*KW +: KW]}, {28'd0, i[3:0]});
         chk($sformatf("wrap_tlast_%0d", i), {31'd0, m_axis_tlast[2]}, 32'd1);
      end
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      step();
      chk("wrap_beat2", {28'd0, beat_count[2*CW +: CW]}, 32'd1);
      chk("wrap_pkt2", {28'd0, pkt_count[2*CW +: CW]}, 32'd1);
      chk("wrap_idle", {29'd0, m_axis_tvalid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ensemble_axis_wrapper.md
Name: ensemble_axis_wrapper

Overview:
- N-channel AXI-Stream front end for the classifier ensemble; one independent stream per classifier, all on one clock.
- Each channel is registered through a 2-entry skid buffer, which gives full throughput, registered tready and 1-cycle latency.
- An optional lockstep mode releases beats on all channels only when every channel can transfer, so classifier outputs stay beat-aligned for downstream voting.
- Per-channel beat and packet counters provide status.

Parameters:
- NUM_CH, 3, number of classifier channels (1..8)
- DATA_WIDTH, 32, tdata width per channel
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per channel
- CNT_WIDTH, 16, width of each beat and packet counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lockstep_req  in  1  requested mode: 1 = lockstep, 0 = independent
- lockstep_active  out  1  mode currently in effect
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_CH*KEEP_WIDTH  per-channel tkeep, sliced the same way
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tready  out  NUM_CH  per-channel ready
- s_axis_tlast  in  NUM_CH  per-channel last
- m_axis_tdata  out  NUM_CH*DATA_WIDTH  output data
- m_axis_tkeep  out  NUM_CH*KEEP_WIDTH  output keep
- m_axis_tvalid  out  NUM_CH  output valid
- m_axis_tready  in  NUM_CH  output ready
- m_axis_tlast  out  NUM_CH  output last
- beat_count  out  NUM_CH*CNT_WIDTH  output beats accepted per channel
- pkt_count  out  NUM_CH*CNT_WIDTH  output beats accepted with tlast=1, per channel

Behaviour:
- Reset (asynchronous assert, release on clk edge): all buffers empty; s_axis_tready=0 on the reset cycle, then 1 from the first clk edge after rst_n deasserts. m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, counters=0, lockstep_active=0. Reset mid-packet discards buffered beats; no partial flush.
- Skid buffer per channel:
  - 2 entries, occupancy 0..2.
  - s_tready_i = (occ_i<2), driven from a register.
  - Input handshake = s_tvalid_i & s_tready_i; push on handshake.
  - Pop on output handshake.
  - Simultaneous push and pop leaves occupancy unchanged, order preserved.
  - Head beat is presented on m_axis_* and is stable while m_tvalid & !m_tready.
  - Latency: a beat accepted at edge k is visible on m_axis at edge k (registered output, 1 cycle from input handshake to output valid).
- Independent mode: m_tvalid_i = (occ_i>0); output handshake_i = m_tvalid_i & m_tready_i.
- Lockstep mode:
  - all_avail = AND over i of (occ_i>0); all_rdy = AND of m_tready.
  - m_tvalid_i = all_avail for every i.
  - Pop all channels together iff all_avail & all_rdy; no channel pops alone.
  - m_tvalid never depends on m_tready, and once asserted stays asserted until the pop (occupancy cannot fall without a pop).
- Mode switch:
  - lockstep_active loads lockstep_req only on a cycle where every buffer is empty after that cycle's push/pop (idle). Otherwise the request stays pending and is re-evaluated each cycle.
  - The switch takes effect for beats presented from the next cycle.
- Counters:
  - beat_count_i increments on each output handshake_i; pkt_count_i increments on output handshake_i with tlast=1.
  - Both wrap modulo 2^CNT_WIDTH and are never saturated.
- tlast and tkeep pass through unmodified. No packet-boundary alignment is enforced in lockstep mode; beats align only by index.
- NUM_CH=1: lockstep is equivalent to independent mode.

Decomposition:
- Shared package ensemble_pkg: default widths, max-channel constant, and a slice helper function for flattened buses.
- Sub-module axis_skid_buffer (DATA_WIDTH, KEEP_WIDTH), instantiated NUM_CH times by a generate loop; it exposes occupancy-nonempty and a pop input, so the wrapper owns the lockstep pop logic.
- Mode register and counters live in the top module.

Test Plan:
- Reset then independent mode; ch0 sends 4 beats 0x11..0x14 with tlast on 0x14, all m_tready=1 -> m_axis_tdata_0 shows 0x11..0x14 on consecutive cycles, 1 cycle after each input; beat_count_0=4, pkt_count_0=1; channels 1 and 2 stay idle.
- Backpressure: ch1 m_tready=0 while 3 beats are offered -> s_tready_1 drops after 2 accepted beats; m_tdata_1 holds the first beat. Raise ready -> 0xA,0xB,0xC delivered in order with no loss or duplicate.
- Lockstep: lockstep_req=1 while idle -> lockstep_active=1 next cycle. Ch0 and ch1 each push 1 beat, ch2 none -> all m_tvalid=0. Ch2 pushes 1 beat -> all three m_tvalid=1 on the same cycle. Ch2 m_tready=0 -> no channel pops; beat_count unchanged.
- Mode request while ch0 buffer holds 1 beat -> lockstep_active stays 0 until that beat drains, then becomes 1 on the following cycle.
- Counter wrap with CNT_WIDTH=4: 17 single-beat packets on ch2 -> beat_count_2=1, pkt_count_2=1.
- Assert rst_n=0 mid-packet with ch0 occupancy=2 -> m_tvalid all 0 immediately, counters 0; after release s_tready=1 and the old data never appears.
